// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, round-constant table and key-expansion state type.
package aes_pkg;
    localparam logic [3:0] NR = 4'd10;
    localparam int NK = 4;
    // Entry r holds Rcon[r+1], so it is indexed directly by the number of rounds already done
    localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sbox.sv
// sbox: NUM parallel AES S-boxes, forward (EN=1) or inverse (EN=0),
// derived from GF(2^8) inversion plus the affine map rather than a lookup table.
module sbox #(
    parameter int NUM = 4,
    parameter bit EN = 1'b1
) (
    input  logic [8*NUM-1:0] i_data,
    output logic [8*NUM-1:0] o_data
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = b[k] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and conveniently maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, sq;
        r = 8'h01;
        sq = a;
        for (int k = 0; k < 7; k++) begin
            sq = gf_mul(sq, sq);
            r = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv(input logic [7:0] s);
        return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    for (genvar n = 0; n < NUM; n++) begin : g_byte
        assign o_data[8*n +: 8] = EN ? fwd(i_data[8*n +: 8]) : inv(i_data[8*n +: 8]);
    end
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128 key schedule, one round key per cycle, emitting
// round keys 0..10 on consecutive cycles after a start request.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic [127:0] rk_out,
    output logic         done
);
    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [127:0] r_key;
    logic [31:0]  w_rot, w_sub, w_t, w_w0, w_w1, w_w2, w_w3;
    logic [7:0]   w_rcon;

    assign w_rot = {r_key[23:0], r_key[31:24]};

    sbox #(.NUM(4), .EN(1'b1)) u_sbox (
        .i_data(w_rot),
        .o_data(w_sub)
    );

    assign w_rcon = (r_cnt < NR) ? RCON[r_cnt] : 8'h00;
    assign w_t    = w_sub ^ {w_rcon, 24'h0};
    assign w_w0   = r_key[127:96] ^ w_t;
    assign w_w1   = r_key[95:64] ^ w_w0;
    assign w_w2   = r_key[63:32] ^ w_w1;
    assign w_w3   = r_key[31:0] ^ w_w2;

    // Key register and counter hold after round 10, so outputs keep their last values in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_key   <= '0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_state <= RUN;
                r_cnt   <= 4'd0;
                r_key   <= key_in;
            end
        end else if (r_cnt == NR) begin
            r_state <= IDLE;
        end else begin
            r_key <= {w_w0, w_w1, w_w2, w_w3};
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign busy     = (r_state == RUN);
    assign rk_valid = busy;
    assign rk_index = r_cnt;
    assign rk_out   = r_key;
    assign done     = busy && (r_cnt == NR);
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: known-answer vectors plus random keys checked against a
// behavioural key-schedule model, with reset, ignore and back-to-back cases.
module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, rk_valid, done;
    logic [3:0]   rk_index;
    logic [127:0] rk_out;

    aes_key_expand dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .busy(busy), .rk_valid(rk_valid), .rk_index(rk_index),
        .rk_out(rk_out), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sb [256];
    logic [127:0] exp_rk [11];
    logic [127:0] got_rk [11];
    vec_t         vecs [2];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        int acc = 0;
        int aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ aa;
            aa = aa << 1;
            if (aa > 255) aa = aa ^ 'h11b;
        end
        return acc[7:0];
    endfunction

    // S-box built from first principles: brute-force inverse, then bitwise affine map
    task automatic build_sbox();
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] iv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gm(x[7:0], y[7:0]) == 8'h01) iv = y[7:0];
            for (int i = 0; i < 8; i++)
                s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {sb[w[3][23:16]] ^ rc, sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]};
        w[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic expand_model(input logic [127:0] key);
        logic [7:0] rc = 8'h01;
        exp_rk[0] = key;
        for (int i = 1; i < 11; i++) begin
            exp_rk[i] = next_rk(exp_rk[i-1], rc);
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] idx,
                             input logic [127:0] rk, input logic d, input logic b);
        chk({tag, "_valid"}, 128'(rk_valid), 128'(v));
        chk({tag, "_index"}, 128'(rk_index), 128'(idx));
        chk({tag, "_rk"}, rk_out, rk);
        chk({tag, "_done"}, 128'(done), 128'(d));
        chk({tag, "_busy"}, 128'(busy), 128'(b));
    endtask

    task automatic do_start(input logic [127:0] key);
        @(negedge clk);
        start = 1'b1;
        key_in = key;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in the cycle presenting rk0; walks all 11 keys plus the following cycle
    task automatic run_seq(input logic [127:0] key, input bit hold, input int poke,
                           input logic [127:0] pkey, input string tag);
        expand_model(key);
        for (int i = 0; i < 11; i++) begin
            got_rk[i] = rk_out;
            check_out($sformatf("%s_rk%0d", tag, i), 1'b1, i[3:0], exp_rk[i], i == 10, 1'b1);
            start = hold || (i == poke);
            key_in = (i == poke) ? pkey : hold ? key : {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        check_out({tag, "_gap"}, 1'b0, 4'd10, exp_rk[10], 1'b0, 1'b0);
    endtask

    initial begin
        logic [127:0] k;
        build_sbox();
        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{128'h0,
                    128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        repeat (2) @(negedge clk);
        check_out("reset", 1'b0, 4'd0, 128'h0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_out("idle", 1'b0, 4'd0, 128'h0, 1'b0, 1'b0);

        for (int v = 0; v < 2; v++) begin
            do_start(vecs[v].key);
            run_seq(vecs[v].key, 1'b0, -1, '0, $sformatf("kat%0d", v));
            chk($sformatf("kat%0d_rk0_const", v), got_rk[0], vecs[v].key);
            chk($sformatf("kat%0d_rk1_const", v), got_rk[1], vecs[v].rk1);
            chk($sformatf("kat%0d_rk10_const", v), got_rk[10], vecs[v].rk10);
        end

        repeat (6) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            do_start(k);
            run_seq(k, 1'b0, -1, '0, "rand");
        end

        do_start(vecs[0].key);
        run_seq(vecs[0].key, 1'b0, 5, vecs[1].key, "ignore");
        chk("ignore_rk10_const", got_rk[10], vecs[0].rk10);

        k = {$urandom, $urandom, $urandom, $urandom};
        do_start(k);
        repeat (3) @(negedge clk);
        chk("abort_pre_index", 128'(rk_index), 128'd3);
        rst = 1'b1;
        #1;
        check_out("abort_async", 1'b0, 4'd0, 128'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_out("abort_after", 1'b0, 4'd0, 128'h0, 1'b0, 1'b0);
        end
        do_start(k);
        run_seq(k, 1'b0, -1, '0, "restart");

        k = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start = 1'b1;
        key_in = k;
        @(negedge clk);
        run_seq(k, 1'b1, -1, '0, "held1");
        @(negedge clk);
        run_seq(k, 1'b1, -1, '0, "held2");
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("held_end_valid", 128'(rk_valid), 128'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
